// File: rtl/operand_fetch.sv
// operand_fetch
// Decode-stage read side of the register file. Drives the register file read
// addresses, resolves operands (x0, optional writeback forwarding), tracks
// outstanding producers in a 32-entry pending scoreboard and captures the
// issued instruction into the ID/EX stage register.
//
// Build option: OPFETCH_WB_BYPASS_EN
//   defined   - same-cycle writeback data is forwarded to the operands and a
//               same-cycle writeback resolves RAW/WAW hazards on that register.
//   undefined - operands always come from the register file; a source or rd
//               matching a valid nonzero wb_addr stalls for one more cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_valid / in_ready      decoded instruction handshake
//   in_rs1/2_addr, in_uses_* source registers and whether they are read
//   in_rd_addr, in_rd_we     destination register
//   rf_rs1/2_addr, _data     combinational register file read port
//   wb_valid, wb_addr, wb_data  writeback this cycle
//   flush                    kill the instruction held in the stage register
//   out_valid / out_ready    ID/EX stage register handshake
//   out_rs1/2, out_rd_*      captured operands and destination
//   pending                  scoreboard, bit 0 always 0
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rs1_addr,
  input  logic [4:0]  in_rs2_addr,
  input  logic        in_uses_rs1,
  input  logic        in_uses_rs2,
  input  logic [4:0]  in_rd_addr,
  input  logic        in_rd_we,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  input  logic [31:0] rf_rs1_data,
  input  logic [31:0] rf_rs2_data,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rs1,
  output logic [31:0] out_rs2,
  output logic [4:0]  out_rd_addr,
  output logic        out_rd_we,
  output logic [31:0] pending
);

  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rs1_q, out_rs1_d;
  logic [31:0] out_rs2_q, out_rs2_d;
  logic [4:0]  out_rd_addr_q, out_rd_addr_d;
  logic        out_rd_we_q, out_rd_we_d;

  logic        wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic        haz_rs1, haz_rs2, haz_waw, hazard;
  logic [31:0] opnd_rs1, opnd_rs2;
  logic        issue;

  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;

  // A writeback to x0 never matches: x0 is neither forwarded nor tracked.
  assign wb_hit_rs1 = wb_valid && (wb_addr == in_rs1_addr) && (in_rs1_addr != 5'd0);
  assign wb_hit_rs2 = wb_valid && (wb_addr == in_rs2_addr) && (in_rs2_addr != 5'd0);
  assign wb_hit_rd  = wb_valid && (wb_addr == in_rd_addr)  && (in_rd_addr  != 5'd0);

  // pending_q[0] is held at 0, so x0 sources never raise a hazard.
  always_comb begin
    opnd_rs1 = (in_rs1_addr == 5'd0) ? 32'd0 : rf_rs1_data;
    opnd_rs2 = (in_rs2_addr == 5'd0) ? 32'd0 : rf_rs2_data;
`ifdef OPFETCH_WB_BYPASS_EN
    if (wb_hit_rs1) opnd_rs1 = wb_data;
    if (wb_hit_rs2) opnd_rs2 = wb_data;
    haz_rs1 = in_uses_rs1 && pending_q[in_rs1_addr] && !wb_hit_rs1;
    haz_rs2 = in_uses_rs2 && pending_q[in_rs2_addr] && !wb_hit_rs2;
    haz_waw = in_rd_we && (in_rd_addr != 5'd0) && pending_q[in_rd_addr] && !wb_hit_rd;
`else
    // Without forwarding a same-cycle writeback is only visible in the
    // register file next cycle, so it stalls like a pending bit.
    haz_rs1 = in_uses_rs1 && (pending_q[in_rs1_addr] || wb_hit_rs1);
    haz_rs2 = in_uses_rs2 && (pending_q[in_rs2_addr] || wb_hit_rs2);
    haz_waw = in_rd_we && (in_rd_addr != 5'd0) && (pending_q[in_rd_addr] || wb_hit_rd);
`endif
    hazard = haz_rs1 || haz_rs2 || haz_waw;
  end

`ifndef OPFETCH_WB_BYPASS_EN
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
`endif

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign issue    = in_valid && in_ready;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_rs1_d     = out_rs1_q;
    out_rs2_d     = out_rs2_q;
    out_rd_addr_d = out_rd_addr_q;
    out_rd_we_d   = out_rd_we_q;
    if (issue) begin
      out_valid_d   = 1'b1;
      out_rs1_d     = opnd_rs1;
      out_rs2_d     = opnd_rs2;
      out_rd_addr_d = in_rd_addr;
      out_rd_we_d   = in_rd_we;
    end else if (flush || out_ready) begin
      out_valid_d   = 1'b0;
    end
  end

  // Order matters: the issue set is applied last so it wins over any clear.
  always_comb begin
    pending_d = pending_q;
    if (flush && out_valid_q && out_rd_we_q) pending_d[out_rd_addr_q] = 1'b0;
    if (wb_valid) pending_d[wb_addr] = 1'b0;
    if (issue && in_rd_we) pending_d[in_rd_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q     <= '0;
      out_valid_q   <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      out_valid_q   <= out_valid_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_rd_addr_q <= out_rd_addr_d;
      out_rd_we_q   <= out_rd_we_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_rd_we   = out_rd_we_q;
  assign pending     = pending_q;

endmodule
